pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_ctrl_pkg.sv | 21 ++
 rtl/pc_seq_ctrl.sv | 103 ++++++++++
 tb/tb_pc_seq_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared PC-control encodings: mux select codes and sequencer states.
// The PC mux decodes the same select values that the sequencer drives.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_NEXT   = 2'b00,
        SEL_FIRST  = 2'b01,
        SEL_INT    = 2'b10,
        SEL_BRANCH = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_IRQ_SAVE = 2'b10,
        ST_IRQ_VEC  = 2'b11
    } pc_state_e;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: boot vector fetch, branch redirect, interrupt entry
// and pipeline flush timing.
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq,
    input  logic       rti,
    input  logic       branch_taken,
    input  logic       stall,
    input  logic       vec_ready,
    output logic [1:0] sel,
    output logic       pc_enable,
    output logic       flush,
    output logic       save_pc,
    output logic       irq_ack,
    output logic       in_isr
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);

    pc_state_e              state_q, state_d;
    logic                   in_isr_q, in_isr_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_BOOT;
            in_isr_q    <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_isr_q    <= in_isr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_isr_d  = rti ? 1'b0 : in_isr_q;
        sel       = SEL_NEXT;
        pc_enable = 1'b0;
        save_pc   = 1'b0;
        irq_ack   = 1'b0;

        // All strobes stay quiet while reset is held, whatever the state.
        if (rst) begin
            case (state_q)
                ST_BOOT: begin
                    sel       = SEL_FIRST;
                    pc_enable = vec_ready;
                    if (vec_ready) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        sel       = SEL_BRANCH;
                        pc_enable = 1'b1;
                    end else if (stall) begin
                        pc_enable = 1'b0;
                    end else if (irq && !in_isr_q) begin
                        irq_ack = 1'b1;
                        state_d = ST_IRQ_SAVE;
                    end else begin
                        pc_enable = 1'b1;
                    end
                end
                ST_IRQ_SAVE: begin
                    save_pc = 1'b1;
                    if (!stall) state_d = ST_IRQ_VEC;
                end
                ST_IRQ_VEC: begin
                    sel       = SEL_INT;
                    pc_enable = vec_ready;
                    if (vec_ready) begin
                        in_isr_d = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // Any non-sequential load restarts the flush window from the top.
    assign redirect = pc_enable && (sel != 2'(SEL_NEXT));

    always_comb begin
        if (redirect)
            flush_cnt_d = FLUSH_INIT;
        else if (stall || flush_cnt_q == '0)
            flush_cnt_d = flush_cnt_q;
        else
            flush_cnt_d = flush_cnt_q - 1'b1;
    end

    assign flush  = rst && ((flush_cnt_q != '0) || redirect);
    assign in_isr = rst && in_isr_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the sequencer.
module tb_pc_seq_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst, irq, rti, branch_taken, stall, vec_ready;
    logic [1:0] sel;
    logic       pc_enable, flush, save_pc, irq_ack, in_isr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .irq(irq), .rti(rti), .branch_taken(branch_taken),
        .stall(stall), .vec_ready(vec_ready), .sel(sel), .pc_enable(pc_enable),
        .flush(flush), .save_pc(save_pc), .irq_ack(irq_ack), .in_isr(in_isr)
    );

    // Behavioural model: where the sequencer is, as plain flags and a count.
    bit m_booting = 1'b1;
    bit m_saving  = 1'b0;
    bit m_vector  = 1'b0;
    bit m_isr     = 1'b0;
    int m_flush_left = 0;
    bit prev_ack  = 1'b0;

    int e_sel;
    bit e_pen, e_flush, e_save, e_ack, e_isr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_sel = 0; e_pen = 0; e_save = 0; e_ack = 0;
        if (rst) begin
            if (m_booting) begin
                e_sel = 1; e_pen = vec_ready;
            end else if (m_saving) begin
                e_save = 1;
            end else if (m_vector) begin
                e_sel = 2; e_pen = vec_ready;
            end else if (branch_taken) begin
                e_sel = 3; e_pen = 1;
            end else if (!stall) begin
                if (irq && !m_isr) e_ack = 1;
                else e_pen = 1;
            end
        end
        e_flush = rst && (m_flush_left > 0 || (e_pen && e_sel != 0));
        e_isr   = rst && m_isr;
    endtask

    task automatic model_update();
        if (!rst) begin
            m_booting = 1; m_saving = 0; m_vector = 0; m_isr = 0; m_flush_left = 0;
        end else begin
            if (e_pen && e_sel != 0) m_flush_left = FC;
            else if (!stall && m_flush_left > 0) m_flush_left--;
            if (rti) m_isr = 0;
            if (m_booting && vec_ready) m_booting = 0;
            else if (m_saving && !stall) begin m_saving = 0; m_vector = 1; end
            else if (m_vector && vec_ready) begin m_vector = 0; m_isr = 1; end
            else if (e_ack) m_saving = 1;
        end
    endtask

    // Drive one cycle's inputs, then compare every output against the model.
    task automatic drive_chk(input bit r, input bit i, input bit t, input bit b,
                             input bit s, input bit v);
        @(negedge clk);
        rst = r; irq = i; rti = t; branch_taken = b; stall = s; vec_ready = v;
        #1;
        model_eval();
        chk("sel", 32'(sel), 32'(e_sel));
        chk("pc_enable", 32'(pc_enable), 32'(e_pen));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("save_pc", 32'(save_pc), 32'(e_save));
        chk("irq_ack", 32'(irq_ack), 32'(e_ack));
        chk("in_isr", 32'(in_isr), 32'(e_isr));
        chk("ack_not_twice", 32'(prev_ack && irq_ack), 32'd0);
        prev_ack = irq_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input bit r, input bit i, input bit t, input bit b,
                       input bit s, input bit v);
        drive_chk(r, i, t, b, s, v);
        tick();
    endtask

    initial begin
        rst = 0; irq = 0; rti = 0; branch_taken = 0; stall = 0; vec_ready = 0;

        // Reset held: everything quiet, even with requests active.
        drive_chk(0, 1, 0, 1, 0, 1);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_pen", 32'(pc_enable), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        tick();
        cyc(0, 0, 0, 0, 0, 0);

        // Boot: vec_ready in the third cycle after release.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        drive_chk(1, 0, 0, 0, 0, 1);
        chk("boot_sel", 32'(sel), 32'd1);
        chk("boot_pen", 32'(pc_enable), 32'd1);
        chk("boot_flush3", 32'(flush), 32'd1);
        tick();
        drive_chk(1, 0, 0, 0, 0, 0);
        chk("boot_sel4", 32'(sel), 32'd0);
        chk("boot_pen4", 32'(pc_enable), 32'd1);
        chk("boot_flush4", 32'(flush), 32'd1);
        tick();
        drive_chk(1, 0, 0, 0, 0, 0);
        chk("boot_flush5", 32'(flush), 32'd1);
        tick();
        drive_chk(1, 0, 0, 0, 0, 0);
        chk("boot_flush6", 32'(flush), 32'd0);
        tick();

        // Interrupt entry with one late vector cycle.
        drive_chk(1, 1, 0, 0, 0, 0);
        chk("irq_ack_n", 32'(irq_ack), 32'd1);
        tick();
        drive_chk(1, 1, 0, 1, 0, 0);
        chk("save_n1", 32'(save_pc), 32'd1);
        tick();
        cyc(1, 1, 0, 0, 0, 0);
        drive_chk(1, 1, 0, 0, 0, 1);
        chk("vec_sel", 32'(sel), 32'd2);
        chk("vec_pen", 32'(pc_enable), 32'd1);
        tick();
        drive_chk(1, 1, 0, 0, 0, 0);
        chk("isr_set", 32'(in_isr), 32'd1);
        chk("isr_masks", 32'(irq_ack), 32'd0);
        tick();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);

        // rti with irq still high: not accepted this cycle, accepted the next.
        drive_chk(1, 1, 1, 0, 0, 0);
        chk("rti_no_ack", 32'(irq_ack), 32'd0);
        tick();
        drive_chk(1, 1, 0, 0, 0, 0);
        chk("rti_ack_m1", 32'(irq_ack), 32'd1);
        tick();
        cyc(1, 0, 0, 0, 0, 0);
        // Reset in IRQ_VEC abandons the interrupt.
        cyc(0, 0, 0, 0, 0, 0);
        drive_chk(0, 1, 0, 0, 0, 1);
        chk("abandon_isr", 32'(in_isr), 32'd0);
        tick();
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Branch during stall, then the window freezes across a 3-cycle stall.
        drive_chk(1, 0, 0, 1, 1, 0);
        chk("bs_sel", 32'(sel), 32'd3);
        chk("bs_flush", 32'(flush), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive_chk(1, 0, 0, 0, 1, 0);
            chk("stall_flush_hold", 32'(flush), 32'd1);
            chk("stall_pen", 32'(pc_enable), 32'd0);
            tick();
        end
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        drive_chk(1, 0, 0, 0, 0, 0);
        chk("stall_flush_done", 32'(flush), 32'd0);
        tick();

        // Two branches one cycle apart: flush stays high without a gap.
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive_chk(1, 0, 0, 0, 0, 0);
            chk("bb_flush", 32'(flush), 32'd1);
            tick();
        end
        drive_chk(1, 0, 0, 0, 0, 0);
        chk("bb_flush_end", 32'(flush), 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(63) != 0,
                $urandom_range(3) == 0,
                $urandom_range(7) == 0,
                $urandom_range(5) == 0,
                $urandom_range(3) == 0,
                $urandom_range(1) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
